// File: rtl/irq_capture_32.sv
// Interrupt/event capture: synchronises up to 32 async lines, latches them as pending
// bits (edge or level), masks them onto dout and derives a registered irq/irq_id pair.
module irq_capture_32 #(
    parameter int SIGNAL_IN_NUM = 32,
    parameter int SYNC_STAGES   = 2,
    localparam int ID_W = (SIGNAL_IN_NUM > 1) ? $clog2(SIGNAL_IN_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SIGNAL_IN_NUM-1:0] irq_in,
    input  logic [SIGNAL_IN_NUM-1:0] irq_mask,
    input  logic [SIGNAL_IN_NUM-1:0] irq_mode,
    input  logic                     clr_valid,
    input  logic [SIGNAL_IN_NUM-1:0] clr_bits,
    output logic                     clr_ready,
    output logic [SIGNAL_IN_NUM-1:0] pend,
    output logic [SIGNAL_IN_NUM-1:0] dout,
    output logic                     irq,
    output logic [ID_W-1:0]          irq_id,
    output logic                     irq_id_valid
);

    localparam logic [SIGNAL_IN_NUM-1:0] ZERO_N = {SIGNAL_IN_NUM{1'b0}};
    localparam logic [ID_W-1:0]          ZERO_ID = {ID_W{1'b0}};

    // Lowest set bit wins; scanning downward lets lower indices overwrite higher ones.
    function automatic logic [ID_W-1:0] lowest_index(input logic [SIGNAL_IN_NUM-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = ZERO_ID;
        for (int i = SIGNAL_IN_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [SIGNAL_IN_NUM-1:0] sync_r [SYNC_STAGES];
    logic [SIGNAL_IN_NUM-1:0] sync_s;
    logic [SIGNAL_IN_NUM-1:0] prev_r;
    logic [SIGNAL_IN_NUM-1:0] pend_r;
    logic [SIGNAL_IN_NUM-1:0] set_s;
    logic [SIGNAL_IN_NUM-1:0] clr_s;
    logic [SIGNAL_IN_NUM-1:0] pend_next_s;
    logic [SIGNAL_IN_NUM-1:0] dout_s;
    logic                     accept_s;
    logic                     clr_ready_r;
    logic                     busy_r;
    logic                     irq_r;
    logic [ID_W-1:0]          irq_id_r;
    logic                     irq_id_valid_r;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign dout_s = pend_r & irq_mask;

    // Per-line synchroniser chain; stage 0 is the only flop seeing the raw async input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= ZERO_N;
            end
        end else begin
            sync_r[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Next pending state: edge bits are sticky with set beating a same-edge clear,
    // level bits simply follow the synchronised input and ignore clears.
    always_comb begin
        accept_s    = 1'b0;
        clr_s       = ZERO_N;
        set_s       = ZERO_N;
        pend_next_s = ZERO_N;
        accept_s    = clr_valid & clr_ready_r & ~busy_r;
        if (accept_s) begin
            clr_s = clr_bits & irq_mode;
        end else begin
            clr_s = ZERO_N;
        end
        set_s       = sync_s & ~prev_r & irq_mode;
        pend_next_s = (irq_mode & ((pend_r & ~clr_s) | set_s)) | (~irq_mode & sync_s);
    end

    // Edge history tracks the synchronised input in both modes so mode switches are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= ZERO_N;
            pend_r <= ZERO_N;
        end else begin
            prev_r <= sync_s;
            pend_r <= pend_next_s;
        end
    end

    // Clear port: one busy cycle after every accept, ready otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            busy_r      <= accept_s;
            clr_ready_r <= ~accept_s;
        end
    end

    // Aggregate interrupt and priority index, registered from the masked vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r          <= 1'b0;
            irq_id_r       <= ZERO_ID;
            irq_id_valid_r <= 1'b0;
        end else begin
            irq_r          <= |dout_s;
            irq_id_r       <= lowest_index(dout_s);
            irq_id_valid_r <= |dout_s;
        end
    end

    assign clr_ready    = clr_ready_r;
    assign pend         = pend_r;
    assign dout         = dout_s;
    assign irq          = irq_r;
    assign irq_id       = irq_id_r;
    assign irq_id_valid = irq_id_valid_r;

endmodule

// File: tb/tb_irq_capture_32.sv
// Directed bench for irq_capture_32: expectations are queued when stimulus is applied
// and popped in order against sampled DUT outputs one time unit after each rising edge.
module tb_irq_capture_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq_in;
    logic [31:0] irq_mask;
    logic [31:0] irq_mode;
    logic        clr_valid;
    logic [31:0] clr_bits;
    logic        clr_ready;
    logic [31:0] pend;
    logic [31:0] dout;
    logic        irq;
    logic [4:0]  irq_id;
    logic        irq_id_valid;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    irq_capture_32 #(.SIGNAL_IN_NUM(32), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .irq_mask     (irq_mask),
        .irq_mode     (irq_mode),
        .clr_valid    (clr_valid),
        .clr_bits     (clr_bits),
        .clr_ready    (clr_ready),
        .pend         (pend),
        .dout         (dout),
        .irq          (irq),
        .irq_id       (irq_id),
        .irq_id_valid (irq_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h expected a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] b1(input logic v);
        return {31'd0, v};
    endfunction

    function automatic logic [31:0] id32(input logic [4:0] v);
        return {27'd0, v};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of stimulus expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        irq_in    = 32'h0;
        irq_mask  = 32'hFFFF_FFFF;
        irq_mode  = 32'hFFFF_FFFF;
        clr_valid = 1'b0;
        clr_bits  = 32'h0;
        #1;

        // T1: reset holds everything at zero even with toggling inputs
        for (int r = 0; r < 3; r++) begin
            irq_in = 32'hFFFF_FFFF;
            step();
            irq_in = 32'h0;
            step();
        end
        push("rst_pend", 32'h0);       check(pend);
        push("rst_dout", 32'h0);       check(dout);
        push("rst_irq", 32'h0);        check(b1(irq));
        push("rst_clr_ready", 32'h0);  check(b1(clr_ready));
        push("rst_id_valid", 32'h0);   check(b1(irq_id_valid));
        rst_n = 1'b1;
        step();
        push("rel_clr_ready", 32'h1);  check(b1(clr_ready));
        push("rel_pend", 32'h0);       check(pend);
        step();
        step();
        push("rel_pend_idle", 32'h0);  check(pend);

        // T2: edge capture on bit 5 with two-stage latency
        irq_in = 32'h20;
        step();
        push("edge_pend_e0", 32'h0);   check(pend);
        step();
        push("edge_pend_e1", 32'h0);   check(pend);
        step();
        push("edge_pend_e2", 32'h20);  check(pend);
        push("edge_irq_e2", 32'h0);    check(b1(irq));
        irq_in = 32'h0;
        step();
        push("edge_irq_e3", 32'h1);    check(b1(irq));
        push("edge_id_e3", 32'd5);     check(id32(irq_id));
        push("edge_idv_e3", 32'h1);    check(b1(irq_id_valid));
        step();
        step();
        step();
        push("edge_pend_hold", 32'h20); check(pend);

        // T3: W1C clear and held-valid spacing
        clr_valid = 1'b1;
        clr_bits  = 32'h20;
        step();
        push("clr_pend", 32'h0);       check(pend);
        push("clr_ready_busy", 32'h0); check(b1(clr_ready));
        push("clr_irq_lag", 32'h1);    check(b1(irq));
        step();
        push("clr_ready_back", 32'h1); check(b1(clr_ready));
        push("clr_irq_off", 32'h0);    check(b1(irq));
        push("clr_id_zero", 32'd0);    check(id32(irq_id));
        push("clr_idv_zero", 32'h0);   check(b1(irq_id_valid));
        step();
        push("clr_second_acc", 32'h0); check(b1(clr_ready));
        step();
        push("clr_second_rdy", 32'h1); check(b1(clr_ready));
        clr_valid = 1'b0;
        clr_bits  = 32'h0;

        // T4: new edge on bit 5 coincides with the clear accept edge
        irq_in = 32'h20;
        step(); step(); step();
        push("col_pre_pend", 32'h20);  check(pend);
        irq_in = 32'h0;
        step();
        step();
        step();
        push("col_pend_held", 32'h20); check(pend);
        irq_in = 32'h20;
        step();
        step();
        clr_valid = 1'b1;
        clr_bits  = 32'h20;
        step();
        push("col_pend_kept", 32'h20); check(pend);
        push("col_acc_ready", 32'h0);  check(b1(clr_ready));
        push("col_irq", 32'h1);        check(b1(irq));
        clr_valid = 1'b0;
        clr_bits  = 32'h0;
        step();
        push("col_irq_after", 32'h1);  check(b1(irq));
        push("col_pend_after", 32'h20); check(pend);
        irq_in    = 32'h0;
        clr_valid = 1'b1;
        clr_bits  = 32'h20;
        step();
        push("col_cleanup", 32'h0);    check(pend);
        clr_valid = 1'b0;
        clr_bits  = 32'h0;
        step();

        // T5: mask and priority
        irq_mask = ~32'h8;
        irq_in   = 32'h88;
        step(); step(); step();
        push("msk_pend", 32'h88);      check(pend);
        push("msk_dout", 32'h80);      check(dout);
        step();
        push("msk_id7", 32'd7);        check(id32(irq_id));
        push("msk_irq", 32'h1);        check(b1(irq));
        irq_mask = 32'hFFFF_FFFF;
        #1;
        push("unmsk_dout", 32'h88);    check(dout);
        step();
        push("unmsk_id3", 32'd3);      check(id32(irq_id));
        irq_mask = 32'h0;
        #1;
        push("allmsk_dout", 32'h0);    check(dout);
        step();
        push("allmsk_irq", 32'h0);     check(b1(irq));
        push("allmsk_id", 32'd0);      check(id32(irq_id));
        push("allmsk_idv", 32'h0);     check(b1(irq_id_valid));
        push("allmsk_pend", 32'h88);   check(pend);
        irq_mask  = 32'hFFFF_FFFF;
        irq_in    = 32'h0;
        clr_valid = 1'b1;
        clr_bits  = 32'h88;
        step();
        push("msk_cleanup", 32'h0);    check(pend);
        clr_valid = 1'b0;
        clr_bits  = 32'h0;
        step();

        // T6: level mode on bit 31
        irq_mode = ~32'h8000_0000;
        irq_in   = 32'h8000_0000;
        step();
        step();
        push("lvl_pend_e1", 32'h0);    check(pend);
        step();
        push("lvl_pend_e2", 32'h8000_0000); check(pend);
        step();
        push("lvl_irq", 32'h1);        check(b1(irq));
        push("lvl_id31", 32'd31);      check(id32(irq_id));
        clr_valid = 1'b1;
        clr_bits  = 32'h8000_0000;
        step();
        push("lvl_clr_noeff", 32'h8000_0000); check(pend);
        push("lvl_clr_acc", 32'h0);    check(b1(clr_ready));
        clr_valid = 1'b0;
        clr_bits  = 32'h0;
        irq_in    = 32'h0;
        step();
        push("lvl_drop_e0", 32'h8000_0000); check(pend);
        step();
        push("lvl_drop_e1", 32'h8000_0000); check(pend);
        step();
        push("lvl_drop_e2", 32'h0);    check(pend);
        push("lvl_irq_lag", 32'h1);    check(b1(irq));
        step();
        push("lvl_irq_off", 32'h0);    check(b1(irq));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
